// File: rtl/parity_bit_counter_if.sv
// Purpose : bundle of the data-side signals of parity_bit_counter (7-bit word in, mode, 8-bit protected word out).
// Latency : none, this is wiring only.
// Backpressure: none; every word is accepted every cycle.
// Ports   : data_in[6:0] (word to protect), control (0 = even, 1 = odd parity), data_out[7:0] ({data_in, parity}).
interface parity_bit_counter_if;
    logic [6:0] data_in;
    logic       control;
    logic [7:0] data_out;

    // The source drives the word and mode and observes the protected word.
    modport master (
        output data_in,
        output control,
        input  data_out
    );

    // The parity block consumes the word and mode and drives the protected word.
    modport slave (
        input  data_in,
        input  control,
        output data_out
    );
endinterface

// File: rtl/parity_bit_counter.sv
// Purpose : registered even/odd parity generator for 7-bit words; data_out = {data_in, parity}.
// Latency : 1 clk (data_out after edge N reflects inputs sampled at edge N).
// Backpressure: none; one word accepted and produced every cycle, no bubbles.
// Ports   : clk (rising-edge clock), rst (async active-high, clears data_out to 8'h00),
//           bus (slave modport: data_in[6:0], control, data_out[7:0]).
module parity_bit_counter (
    input  logic                 clk,
    input  logic                 rst,
    parity_bit_counter_if.slave  bus
);

    // Full adder returning {carry, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        logic s;
        logic co;
        s  = a ^ b ^ c;
        co = (a & b) | (a & c) | (b & c);
        return {co, s};
    endfunction

    logic [1:0] fa_lo;     // ones in data_in[2:0], as {weight-2, weight-1}
    logic [1:0] fa_hi;     // ones in data_in[5:3]
    logic [1:0] fa_unit;   // weight-1 column: fa_lo sum + fa_hi sum + data_in[6]
    logic [1:0] fa_two;    // weight-2 column: both carries plus the carry out of fa_unit
    logic [2:0] ones;
    logic       parity;

    // Adder tree popcount: two 3-bit full adders, then combine the weight-1
    // column with bit 6 and fold the three weight-2 carries together.
    always_comb begin
        fa_lo   = full_add(bus.data_in[0], bus.data_in[1], bus.data_in[2]);
        fa_hi   = full_add(bus.data_in[3], bus.data_in[4], bus.data_in[5]);
        fa_unit = full_add(fa_lo[0], fa_hi[0], bus.data_in[6]);
        fa_two  = full_add(fa_lo[1], fa_hi[1], fa_unit[1]);
        ones    = {fa_two[1], fa_two[0], fa_unit[0]};
        // Even mode: parity equals the ones-count LSB so the total is even;
        // odd mode inverts it.
        parity  = ones[0] ^ bus.control;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.data_out <= 8'h00;
        end else begin
            bus.data_out <= {bus.data_in, parity};
        end
    end

endmodule

// File: tb/tb_parity_bit_counter.sv
module tb_parity_bit_counter;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic [7:0] exp_q[$];

    parity_bit_counter_if bus ();

    parity_bit_counter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: count ones arithmetically and pick the bit that makes the
    // total ones count of the 8-bit word match the requested parity.
    function automatic logic [7:0] model(input logic [6:0] d, input logic c);
        int  n;
        logic p;
        n = 0;
        for (int i = 0; i < 7; i++) n += int'(d[i]);
        p = (((n % 2) == 1) != (c == 1'b1)) ? 1'b1 : 1'b0;
        return {d, p};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive a word on the falling edge; expectation is due after the next rising edge.
    task automatic drive(input logic [6:0] d, input logic c, input logic [7:0] exp);
        @(negedge clk);
        bus.data_in = d;
        bus.control = c;
        exp_q.push_back(exp);
    endtask

    // Half-cycle reset pulse between edges: output must clear immediately,
    // and the word already on the inputs is still loaded at the next edge.
    task automatic mid_pulse();
        #1 rst = 1'b1;
        #1 check("midstream_clear", bus.data_out, 8'h00);
        #1 rst = 1'b0;
    endtask

    // Monitor: one sample per cycle, 1 time unit after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                check("reset_hold", bus.data_out, 8'h00);
            end else if (exp_q.size() > 0) begin
                check("scoreboard", bus.data_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] v;
        logic [6:0] rd;
        logic       rc;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.data_in = 7'b1111111;
        bus.control = 1'b1;
        #1 check("reset_async", bus.data_out, 8'h00);
        repeat (3) @(posedge clk);

        // Release with the all-ones odd-mode word still applied.
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(8'b11111110);

        drive(7'b0000000, 1'b0, 8'b00000000);
        drive(7'b0000000, 1'b1, 8'b00000001);
        drive(7'b1010101, 1'b0, 8'b10101010);
        drive(7'b1010101, 1'b1, 8'b10101011);
        drive(7'b1111111, 1'b0, 8'b11111111);
        drive(7'b1111111, 1'b1, 8'b11111110);
        drive(7'b0000001, 1'b0, 8'b00000011);

        // Exhaustive sweep of {data_in, control}, back to back.
        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            drive(v[7:1], v[0], model(v[7:1], v[0]));
            if (i == 100 || i == 201) mid_pulse();
        end

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 300; i++) begin
            rd = 7'($urandom);
            rc = 1'($urandom);
            drive(rd, rc, model(rd, rc));
            if ($urandom_range(0, 39) == 0) mid_pulse();
        end

        // Reset raised exactly on a rising edge: reset wins, pending word dropped.
        @(posedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("edge_reset", bus.data_out, 8'h00);
        rst = 1'b0;
        exp_q.push_back(model(bus.data_in, bus.control));
        drive(7'b0110011, 1'b1, 8'b01100111);
        drive(7'b1000000, 1'b0, 8'b10000001);

        // Bounded drain: every expected word must have been consumed.
        repeat (4) @(posedge clk);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
